hazard_sequencer: RTL and testbench

- Pipeline control block for the 5-stage RISC-V core.
- Owns branch resolution: PCSrc is the AND of the EX-stage Branch and Zero signals, ORed with Jump.
- Sequences stalls and flushes for load-use hazards, taken branches and external memory holds.
- Sits beside the forwarding unit; drives the enable/clear inputs of the PC, IF/ID and ID/EX registers, and keeps saturating performance counters.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_sequencer_sat_counter.sv | 30 +++
 rtl/hazard_sequencer.sv | 147 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard sequencer.
//   state_t       : sequencer FSM states
//   REG_W_DEFAULT : default register-index width
//   X0            : index of the hard-wired zero register
package hazard_pkg;

    localparam int unsigned REG_W_DEFAULT = 5;
    localparam int unsigned X0            = 0;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        HOLD
    } state_t;

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_inc          : count enable
//   i_clr          : synchronous clear, wins over i_inc
//   o_q            : count value, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush sequencer for a 5-stage RISC-V core.
// Resolves branches in EX, inserts load-use bubbles and freezes the front-end
// on data-memory holds; counts stall cycles and taken-branch flushes.
//   i_clk, i_rst_n                      : clock, async active-low reset
//   i_branch_e, i_zero_e, i_jump_e      : EX-stage branch resolution inputs
//   i_memread_e, i_rd_e                 : EX-stage load and its destination
//   i_rs1_d, i_rs2_d                    : ID-stage sources
//   i_hold_req                          : data-memory wait
//   i_cnt_clr                           : synchronous clear of both counters
//   o_pc_src_e                          : take branch/jump target
//   o_stall_f/d/e, o_flush_d/e          : pipeline register enables/clears
//   o_stall_cnt, o_flush_cnt            : saturating performance counters
module hazard_sequencer #(
    parameter int unsigned LU_BUBBLES = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned REG_W      = hazard_pkg::REG_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_branch_e,
    input  logic             i_zero_e,
    input  logic             i_jump_e,
    input  logic             i_memread_e,
    input  logic [REG_W-1:0] i_rd_e,
    input  logic [REG_W-1:0] i_rs1_d,
    input  logic [REG_W-1:0] i_rs2_d,
    input  logic             i_hold_req,
    input  logic             i_cnt_clr,
    output logic             o_pc_src_e,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_stall_e,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    import hazard_pkg::*;

    localparam int unsigned      BUB_W    = 3;
    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(LU_BUBBLES - 1);

    state_t           r_state, w_state_d, r_ret, w_ret_d, w_cur;
    logic [BUB_W-1:0] r_bub, w_bub_d;
    logic             w_taken, w_lu_hit;
    logic             w_pc_src, w_stall_f, w_stall_d, w_stall_e, w_flush_d, w_flush_e;

    assign w_taken  = (i_branch_e & i_zero_e) | i_jump_e;
    assign w_lu_hit = i_memread_e & (i_rd_e != REG_W'(X0)) &
                      ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d));

    // Leaving HOLD behaves as the saved state in the same cycle.
    always_comb begin
        if (r_state == HOLD && !i_hold_req) begin
            w_cur = r_ret;
        end else begin
            w_cur = r_state;
        end
    end

    always_comb begin
        w_state_d = w_cur;
        w_ret_d   = r_ret;
        w_bub_d   = r_bub;
        w_pc_src  = 1'b0;
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        unique case (w_cur)
            RUN: begin
                if (i_hold_req) begin
                    {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
                    w_state_d = HOLD;
                    w_ret_d   = RUN;
                end else if (w_taken) begin
                    // Any lu_hit is moot: the dependent instruction is flushed.
                    {w_pc_src, w_flush_d, w_flush_e} = 3'b111;
                end else if (w_lu_hit) begin
                    {w_stall_f, w_stall_d, w_flush_e} = 3'b111;
                    if (LU_BUBBLES > 1) begin
                        w_bub_d   = BUB_LOAD;
                        w_state_d = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                if (i_hold_req) begin
                    {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
                    w_state_d = HOLD;
                    w_ret_d   = LU_STALL;
                end else begin
                    // Load already left EX; taken cannot be real here.
                    {w_stall_f, w_stall_d, w_flush_e} = 3'b111;
                    w_bub_d = r_bub - 1'b1;
                    if (r_bub == BUB_W'(1)) begin
                        w_state_d = RUN;
                    end
                end
            end
            HOLD: begin
                {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
            end
            default: begin
                w_state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_ret   <= RUN;
            r_bub   <= '0;
        end else begin
            r_state <= w_state_d;
            r_ret   <= w_ret_d;
            r_bub   <= w_bub_d;
        end
    end

    // Force every control output low while reset is asserted.
    assign o_pc_src_e = i_rst_n & w_pc_src;
    assign o_stall_f  = i_rst_n & w_stall_f;
    assign o_stall_d  = i_rst_n & w_stall_d;
    assign o_stall_e  = i_rst_n & w_stall_e;
    assign o_flush_d  = i_rst_n & w_flush_d;
    assign o_flush_e  = i_rst_n & w_flush_e;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (o_stall_f),
        .i_clr   (i_cnt_clr),
        .o_q     (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (o_pc_src_e),
        .i_clr   (i_cnt_clr),
        .o_q     (o_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer.
// DUT A: LU_BUBBLES=1, CNT_W=4.  DUT B: LU_BUBBLES=3, CNT_W=16.
// Control vector order: {pc_src, stall_f, stall_d, stall_e, flush_d, flush_e}.
module tb_hazard_sequencer;

    typedef struct packed {
        logic       rst_n;
        logic       hold;
        logic       br;
        logic       zr;
        logic       jp;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       clr;
    } stim_t;

    typedef struct {
        bit         dut;
        logic [5:0] ctl;
        int         sc;
        int         fc;
        int         idx;
    } exp_t;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b011001;
    localparam logic [5:0] C_FL   = 6'b100011;
    localparam logic [5:0] C_HOLD = 6'b011100;

    logic  clk = 1'b0;
    stim_t in_a, in_b;
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    step_idx = 0;

    logic        a_pc, a_sf, a_sd, a_se, a_fd, a_fe;
    logic [3:0]  a_sc, a_fc;
    logic        b_pc, b_sf, b_sd, b_se, b_fd, b_fe;
    logic [15:0] b_sc, b_fc;

    always #5 clk = ~clk;

    hazard_sequencer #(.LU_BUBBLES(1), .CNT_W(4), .REG_W(5)) dut_a (
        .i_clk       (clk),
        .i_rst_n     (in_a.rst_n),
        .i_branch_e  (in_a.br),
        .i_zero_e    (in_a.zr),
        .i_jump_e    (in_a.jp),
        .i_memread_e (in_a.mr),
        .i_rd_e      (in_a.rd),
        .i_rs1_d     (in_a.rs1),
        .i_rs2_d     (in_a.rs2),
        .i_hold_req  (in_a.hold),
        .i_cnt_clr   (in_a.clr),
        .o_pc_src_e  (a_pc),
        .o_stall_f   (a_sf),
        .o_stall_d   (a_sd),
        .o_stall_e   (a_se),
        .o_flush_d   (a_fd),
        .o_flush_e   (a_fe),
        .o_stall_cnt (a_sc),
        .o_flush_cnt (a_fc)
    );

    hazard_sequencer #(.LU_BUBBLES(3), .CNT_W(16), .REG_W(5)) dut_b (
        .i_clk       (clk),
        .i_rst_n     (in_b.rst_n),
        .i_branch_e  (in_b.br),
        .i_zero_e    (in_b.zr),
        .i_jump_e    (in_b.jp),
        .i_memread_e (in_b.mr),
        .i_rd_e      (in_b.rd),
        .i_rs1_d     (in_b.rs1),
        .i_rs2_d     (in_b.rs2),
        .i_hold_req  (in_b.hold),
        .i_cnt_clr   (in_b.clr),
        .o_pc_src_e  (b_pc),
        .o_stall_f   (b_sf),
        .o_stall_d   (b_sd),
        .o_stall_e   (b_se),
        .o_flush_d   (b_fd),
        .o_flush_e   (b_fe),
        .o_stall_cnt (b_sc),
        .o_flush_cnt (b_fc)
    );

    function automatic stim_t mk(input logic rst_n, input logic hold, input logic br,
                                 input logic zr, input logic jp, input logic mr,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic clr);
        stim_t s;
        s.rst_n = rst_n; s.hold = hold; s.br = br; s.zr = zr; s.jp = jp;
        s.mr = mr; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.clr = clr;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the expected response for that cycle.
    // Counter expectations are the values already registered before this cycle's edge.
    task automatic step(input bit dut, input stim_t s, input logic [5:0] ctl,
                        input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        if (dut) in_b = s;
        else     in_a = s;
        e.dut = dut; e.ctl = ctl; e.sc = sc; e.fc = fc; e.idx = step_idx;
        sb.push_back(e);
        step_idx++;
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [5:0] act_ctl;
            int         act_sc, act_fc;
            e = sb.pop_front();
            if (e.dut) begin
                act_ctl = {b_pc, b_sf, b_sd, b_se, b_fd, b_fe};
                act_sc  = int'(b_sc);
                act_fc  = int'(b_fc);
            end else begin
                act_ctl = {a_pc, a_sf, a_sd, a_se, a_fd, a_fe};
                act_sc  = int'(a_sc);
                act_fc  = int'(a_fc);
            end
            checks += 3;
            if (act_ctl !== e.ctl) begin
                errors++;
                $display("FAIL ctl dut%0d step %0d actual %b required %b",
                         e.dut, e.idx, act_ctl, e.ctl);
            end
            if (act_sc != e.sc) begin
                errors++;
                $display("FAIL stall_cnt dut%0d step %0d actual %0d required %0d",
                         e.dut, e.idx, act_sc, e.sc);
            end
            if (act_fc != e.fc) begin
                errors++;
                $display("FAIL flush_cnt dut%0d step %0d actual %0d required %0d",
                         e.dut, e.idx, act_fc, e.fc);
            end
        end
    end

    stim_t idle, idle_rst;

    initial begin
        idle     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_rst = mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        in_a = idle_rst;
        in_b = idle_rst;

        // ---------------- DUT A: LU_BUBBLES=1, CNT_W=4 ----------------
        step(0, idle_rst, C_NONE, 0, 0);
        step(0, idle_rst, C_NONE, 0, 0);
        step(0, idle, C_NONE, 0, 0);
        step(0, idle, C_NONE, 0, 0);
        // load-use x5 -> single bubble
        step(0, mk(1, 0, 0, 0, 0, 1, 5, 5, 1, 0), C_LU, 0, 0);
        step(0, idle, C_NONE, 1, 0);
        // load into x0 never stalls
        step(0, mk(1, 0, 0, 0, 0, 1, 0, 3, 0, 0), C_NONE, 1, 0);
        step(0, idle, C_NONE, 1, 0);
        // taken branch beats load-use
        step(0, mk(1, 0, 1, 1, 0, 1, 5, 5, 0, 0), C_FL, 1, 0);
        step(0, idle, C_NONE, 1, 1);
        // branch not taken
        step(0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), C_NONE, 1, 1);
        // jump
        step(0, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0), C_FL, 1, 1);
        step(0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), C_NONE, 1, 2);
        // branch held in EX through a 4-cycle hold, resolves right after
        for (int i = 0; i < 4; i++) begin
            step(0, mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0), C_HOLD, i, 0);
        end
        step(0, mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0), C_FL, 4, 0);
        step(0, idle, C_NONE, 4, 1);
        step(0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), C_NONE, 4, 1);
        // saturation at 15 over 20 stall cycles
        for (int i = 0; i < 20; i++) begin
            step(0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), C_HOLD, (i < 15) ? i : 15, 0);
        end
        // clear wins over a same-cycle stall increment
        step(0, mk(1, 0, 0, 0, 0, 1, 9, 2, 9, 1), C_LU, 15, 0);
        step(0, idle, C_NONE, 0, 0);

        // ---------------- DUT B: LU_BUBBLES=3, CNT_W=16 ----------------
        step(1, idle_rst, C_NONE, 0, 0);
        step(1, idle, C_NONE, 0, 0);
        // one hit -> three stall cycles
        step(1, mk(1, 0, 0, 0, 0, 1, 7, 1, 7, 0), C_LU, 0, 0);
        step(1, idle, C_LU, 1, 0);
        step(1, idle, C_LU, 2, 0);
        step(1, idle, C_NONE, 3, 0);
        // hold preempts LU_STALL, bubble count preserved; taken ignored on resume
        step(1, mk(1, 0, 0, 0, 0, 1, 7, 7, 0, 0), C_LU, 3, 0);
        step(1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), C_HOLD, 4, 0);
        step(1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), C_HOLD, 5, 0);
        step(1, mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0), C_LU, 6, 0);
        step(1, idle, C_LU, 7, 0);
        step(1, idle, C_NONE, 8, 0);
        // reset in the middle of LU_STALL
        step(1, mk(1, 0, 0, 0, 0, 1, 7, 7, 0, 0), C_LU, 8, 0);
        step(1, idle, C_LU, 9, 0);
        step(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_NONE, 0, 0);
        step(1, idle, C_NONE, 0, 0);
        step(1, idle, C_NONE, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
